lc3_control: RTL and testbench

Multi-cycle control sequencer for the LC-3 datapath. It sits directly upstream of the register file and drives its `regWE`, `DR`, `SR1` and `SR2` inputs. It also drives the bus-source select, the PC/MAR/MDR/IR load strobes, the address-adder selects, the ALU opcode and the memory handshake. It holds the IR and the NZP condition codes, and steps each instruction through fetch, decode and execute states.

---
 rtl/lc3_control.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_lc3_control.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_control.sv
// LC-3 multi-cycle control sequencer.
// It holds IR, NZP and the instruction state. Every datapath control output
// is decoded combinationally from the current state and IR.
module lc3_control (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] Buss,
    input  logic        mem_ready,
    output logic        regWE,
    output logic [2:0]  DR,
    output logic [2:0]  SR1,
    output logic [2:0]  SR2,
    output logic [15:0] ir,
    output logic [1:0]  bus_sel,
    output logic        ld_pc,
    output logic        ld_mar,
    output logic        ld_mdr,
    output logic [1:0]  pc_sel,
    output logic        addr1_sel,
    output logic [1:0]  addr2_sel,
    output logic        mdr_sel,
    output logic [1:0]  alu_op,
    output logic        alu_imm,
    output logic        mem_en,
    output logic        mem_we,
    output logic        illegal,
    output logic [2:0]  nzp
);

    typedef enum logic [3:0] {
        S_F1  = 4'd0,
        S_F2  = 4'd1,
        S_F3  = 4'd2,
        S_DEC = 4'd3,
        S_ALU = 4'd4,
        S_BR  = 4'd5,
        S_JMP = 4'd6,
        S_JSR = 4'd7,
        S_LEA = 4'd8,
        S_LD1 = 4'd9,
        S_LD2 = 4'd10,
        S_LD3 = 4'd11,
        S_ST1 = 4'd12,
        S_ST2 = 4'd13,
        S_ST3 = 4'd14
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic [2:0]  nzp_q, nzp_d;

    logic        regwe_s, ld_pc_s, ld_mar_s, ld_mdr_s;
    logic        mem_en_s, mem_we_s, illegal_s;
    logic [3:0]  opcode_s;

    // Condition codes for a value on the bus: exactly one bit set.
    function automatic logic [2:0] cc_of(input logic [15:0] v);
        logic zero;
        zero  = (v == 16'h0000);
        cc_of = {v[15], zero, (~v[15]) & (~zero)};
    endfunction

    assign opcode_s = ir_q[15:12];
    assign ir       = ir_q;
    assign nzp      = nzp_q;

    // Next-state, IR capture and condition-code update.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        nzp_d   = nzp_q;
        case (state_q)
            S_F1: state_d = S_F2;
            S_F2: begin
                if (mem_ready) begin
                    state_d = S_F3;
                end else begin
                    state_d = S_F2;
                end
            end
            S_F3: begin
                ir_d    = Buss;
                state_d = S_DEC;
            end
            S_DEC: begin
                case (opcode_s)
                    4'b0001, 4'b0101, 4'b1001: state_d = S_ALU;
                    4'b0000:                   state_d = S_BR;
                    4'b1100:                   state_d = S_JMP;
                    4'b0100:                   state_d = S_JSR;
                    4'b0010, 4'b0110:          state_d = S_LD1;
                    4'b0011, 4'b0111:          state_d = S_ST1;
                    4'b1110:                   state_d = S_LEA;
                    default:                   state_d = S_F1;
                endcase
            end
            S_ALU: begin
                nzp_d   = cc_of(Buss);
                state_d = S_F1;
            end
            S_LD1: state_d = S_LD2;
            S_LD2: begin
                if (mem_ready) begin
                    state_d = S_LD3;
                end else begin
                    state_d = S_LD2;
                end
            end
            S_LD3: begin
                nzp_d   = cc_of(Buss);
                state_d = S_F1;
            end
            S_ST1: state_d = S_ST2;
            S_ST2: state_d = S_ST3;
            S_ST3: begin
                if (mem_ready) begin
                    state_d = S_F1;
                end else begin
                    state_d = S_ST3;
                end
            end
            S_BR, S_JMP, S_JSR, S_LEA: state_d = S_F1;
            default: state_d = S_F1;
        endcase
    end

    // Datapath control decode from state and IR.
    always_comb begin
        regwe_s   = 1'b0;
        ld_pc_s   = 1'b0;
        ld_mar_s  = 1'b0;
        ld_mdr_s  = 1'b0;
        mem_en_s  = 1'b0;
        mem_we_s  = 1'b0;
        illegal_s = 1'b0;
        DR        = 3'd0;
        SR1       = 3'd0;
        SR2       = 3'd0;
        bus_sel   = 2'd0;
        pc_sel    = 2'd0;
        addr1_sel = 1'b0;
        addr2_sel = 2'd0;
        mdr_sel   = 1'b0;
        alu_op    = 2'd0;
        alu_imm   = 1'b0;
        case (state_q)
            S_F1: begin
                bus_sel  = 2'd0;
                ld_mar_s = 1'b1;
                ld_pc_s  = 1'b1;
                pc_sel   = 2'd0;
            end
            S_F2, S_LD2: begin
                mem_en_s = 1'b1;
                mdr_sel  = 1'b0;
                ld_mdr_s = mem_ready;
            end
            S_F3: bus_sel = 2'd3;
            S_DEC: begin
                case (opcode_s)
                    4'b0001, 4'b0101, 4'b1001, 4'b0000, 4'b1100, 4'b0100,
                    4'b0010, 4'b0110, 4'b0011, 4'b0111, 4'b1110: illegal_s = 1'b0;
                    default: illegal_s = 1'b1;
                endcase
            end
            S_ALU: begin
                SR1     = ir_q[8:6];
                SR2     = ir_q[2:0];
                DR      = ir_q[11:9];
                bus_sel = 2'd1;
                regwe_s = 1'b1;
                case (opcode_s)
                    4'b0001: begin
                        alu_op  = 2'd0;
                        alu_imm = ir_q[5];
                    end
                    4'b0101: begin
                        alu_op  = 2'd1;
                        alu_imm = ir_q[5];
                    end
                    default: begin
                        alu_op  = 2'd2;
                        alu_imm = 1'b0;
                    end
                endcase
            end
            S_LEA: begin
                addr1_sel = 1'b0;
                addr2_sel = 2'd2;
                bus_sel   = 2'd2;
                regwe_s   = 1'b1;
                DR        = ir_q[11:9];
            end
            S_BR: begin
                if ((ir_q[11:9] & nzp_q) != 3'b000) begin
                    addr1_sel = 1'b0;
                    addr2_sel = 2'd2;
                    pc_sel    = 2'd1;
                    ld_pc_s   = 1'b1;
                end else begin
                    ld_pc_s   = 1'b0;
                end
            end
            S_JMP: begin
                SR1       = ir_q[8:6];
                addr1_sel = 1'b1;
                addr2_sel = 2'd0;
                pc_sel    = 2'd1;
                ld_pc_s   = 1'b1;
            end
            S_JSR: begin
                // The old R7 is read before the edge that writes the link.
                bus_sel = 2'd0;
                DR      = 3'd7;
                regwe_s = 1'b1;
                SR1     = ir_q[8:6];
                pc_sel  = 2'd1;
                ld_pc_s = 1'b1;
                if (ir_q[11]) begin
                    addr1_sel = 1'b0;
                    addr2_sel = 2'd3;
                end else begin
                    addr1_sel = 1'b1;
                    addr2_sel = 2'd0;
                end
            end
            S_LD1, S_ST1: begin
                bus_sel  = 2'd2;
                ld_mar_s = 1'b1;
                // Opcode bit 14 distinguishes base+offset6 from PC+offset9.
                if (ir_q[14]) begin
                    addr1_sel = 1'b1;
                    addr2_sel = 2'd1;
                    SR1       = ir_q[8:6];
                end else begin
                    addr1_sel = 1'b0;
                    addr2_sel = 2'd2;
                end
            end
            S_LD3: begin
                bus_sel = 2'd3;
                regwe_s = 1'b1;
                DR      = ir_q[11:9];
            end
            S_ST2: begin
                SR1      = ir_q[11:9];
                alu_op   = 2'd3;
                bus_sel  = 2'd1;
                mdr_sel  = 1'b1;
                ld_mdr_s = 1'b1;
            end
            S_ST3: begin
                mem_en_s = 1'b1;
                mem_we_s = 1'b1;
            end
            default: begin
                bus_sel = 2'd0;
            end
        endcase
    end

    // Strobes are held off for the whole time reset is asserted.
    assign regWE   = regwe_s   & ~reset;
    assign ld_pc   = ld_pc_s   & ~reset;
    assign ld_mar  = ld_mar_s  & ~reset;
    assign ld_mdr  = ld_mdr_s  & ~reset;
    assign mem_en  = mem_en_s  & ~reset;
    assign mem_we  = mem_we_s  & ~reset;
    assign illegal = illegal_s & ~reset;

    // State, IR and condition-code registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_F1;
            ir_q    <= 16'h0000;
            nzp_q   <= 3'b010;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            nzp_q   <= nzp_d;
        end
    end

endmodule

// File: tb/tb_lc3_control.sv
// Directed testbench for lc3_control. Inputs change 2 time units after each
// rising edge; outputs are checked 1 unit later, well away from the edges.
module tb_lc3_control;

    logic        clk;
    logic        reset;
    logic [15:0] Buss;
    logic        mem_ready;
    logic        regWE;
    logic [2:0]  DR, SR1, SR2;
    logic [15:0] ir;
    logic [1:0]  bus_sel;
    logic        ld_pc, ld_mar, ld_mdr;
    logic [1:0]  pc_sel;
    logic        addr1_sel;
    logic [1:0]  addr2_sel;
    logic        mdr_sel;
    logic [1:0]  alu_op;
    logic        alu_imm;
    logic        mem_en, mem_we, illegal;
    logic [2:0]  nzp;

    int vectors;
    int miscompares;

    lc3_control dut (
        .clk(clk), .reset(reset), .Buss(Buss), .mem_ready(mem_ready),
        .regWE(regWE), .DR(DR), .SR1(SR1), .SR2(SR2), .ir(ir),
        .bus_sel(bus_sel), .ld_pc(ld_pc), .ld_mar(ld_mar), .ld_mdr(ld_mdr),
        .pc_sel(pc_sel), .addr1_sel(addr1_sel), .addr2_sel(addr2_sel),
        .mdr_sel(mdr_sel), .alu_op(alu_op), .alu_imm(alu_imm),
        .mem_en(mem_en), .mem_we(mem_we), .illegal(illegal), .nzp(nzp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to the middle of the next cycle.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Drive one zero- or multi-wait fetch starting in F1; ends in DEC.
    task automatic fetch(input logic [15:0] instr, input int waits);
        mem_ready = 1'b0; Buss = 16'h0000;
        tick();
        for (int i = 0; i < waits; i++) begin
            mem_ready = 1'b0;
            tick();
        end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0; Buss = instr;
        tick();
        Buss = 16'h0000;
        #1;
    endtask

    task automatic test_reset();
        logic [6:0] strobes;
        reset = 1'b1; Buss = 16'h0000; mem_ready = 1'b0;
        tick(); tick();
        #1;
        strobes = {regWE, ld_pc, ld_mar, ld_mdr, mem_en, mem_we, illegal};
        vectors++;
        if (strobes !== 7'b0) begin
            $display("FAIL reset_strobes: got %b want %b", strobes, 7'b0); miscompares++;
        end
        vectors++;
        if (nzp !== 3'b010 || ir !== 16'h0000) begin
            $display("FAIL reset_regs: nzp=%b ir=%h want 010/0000", nzp, ir); miscompares++;
        end
        reset = 1'b0;
        #1;
        vectors++;
        if ({ld_mar, ld_pc, bus_sel, pc_sel, regWE} !== {1'b1, 1'b1, 2'd0, 2'd0, 1'b0}) begin
            $display("FAIL reset_f1: ld_mar=%b ld_pc=%b bus_sel=%0d pc_sel=%0d want 1 1 0 0",
                     ld_mar, ld_pc, bus_sel, pc_sel); miscompares++;
        end
    endtask

    task automatic test_add_imm();
        fetch(16'h1265, 0);
        vectors++;
        if (ir !== 16'h1265 || illegal !== 1'b0 || regWE !== 1'b0) begin
            $display("FAIL add_dec: ir=%h illegal=%b regWE=%b want 1265 0 0", ir, illegal, regWE);
            miscompares++;
        end
        tick();
        Buss = 16'h0005;
        #1;
        vectors++;
        if ({regWE, DR, alu_imm, alu_op, SR1, bus_sel} !== {1'b1, 3'd1, 1'b1, 2'd0, 3'd1, 2'd1}) begin
            $display("FAIL add_exec: regWE=%b DR=%0d imm=%b op=%0d SR1=%0d bus=%0d want 1 1 1 0 1 1",
                     regWE, DR, alu_imm, alu_op, SR1, bus_sel); miscompares++;
        end
        tick();
        Buss = 16'h0000;
        #1;
        vectors++;
        if (nzp !== 3'b001 || ld_mar !== 1'b1) begin
            $display("FAIL add_cc: nzp=%b ld_mar=%b want 001 1", nzp, ld_mar); miscompares++;
        end
    endtask

    task automatic test_branch();
        fetch(16'h1020, 0);
        tick();
        Buss = 16'h0000;
        tick();
        vectors++;
        if (nzp !== 3'b010) begin
            $display("FAIL zero_cc: got %b want 010", nzp); miscompares++;
        end
        fetch(16'h0402, 0);
        tick();
        #1;
        vectors++;
        if ({ld_pc, pc_sel, addr2_sel, addr1_sel} !== {1'b1, 2'd1, 2'd2, 1'b0}) begin
            $display("FAIL brz_taken: ld_pc=%b pc_sel=%0d addr2=%0d want 1 1 2",
                     ld_pc, pc_sel, addr2_sel); miscompares++;
        end
        tick();
        fetch(16'h0802, 0);
        tick();
        #1;
        vectors++;
        if (ld_pc !== 1'b0 || pc_sel !== 2'd0) begin
            $display("FAIL brn_not_taken: ld_pc=%b pc_sel=%0d want 0 0", ld_pc, pc_sel); miscompares++;
        end
        tick();
        #1;
        vectors++;
        if (ld_mar !== 1'b1) begin
            $display("FAIL br_to_f1: ld_mar=%b want 1", ld_mar); miscompares++;
        end
    endtask

    task automatic test_ldr_wait();
        int mem_cycles;
        fetch(16'h64FF, 0);
        tick();
        #1;
        vectors++;
        if ({ld_mar, bus_sel, addr1_sel, addr2_sel, SR1} !== {1'b1, 2'd2, 1'b1, 2'd1, 3'd3}) begin
            $display("FAIL ldr_addr: ld_mar=%b bus=%0d a1=%b a2=%0d SR1=%0d want 1 2 1 1 3",
                     ld_mar, bus_sel, addr1_sel, addr2_sel, SR1); miscompares++;
        end
        tick();
        mem_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            mem_ready = (i == 2);
            #1;
            if (mem_en === 1'b1) mem_cycles++;
            vectors++;
            if (ld_mdr !== (i == 2)) begin
                $display("FAIL ldr_ld_mdr: cycle %0d got %b want %b", i, ld_mdr, (i == 2));
                miscompares++;
            end
            tick();
        end
        mem_ready = 1'b0;
        vectors++;
        if (mem_cycles != 3) begin
            $display("FAIL ldr_mem_en: %0d cycles, want 3", mem_cycles); miscompares++;
        end
        Buss = 16'h8000;
        #1;
        vectors++;
        if ({regWE, DR, bus_sel, mem_en} !== {1'b1, 3'd2, 2'd3, 1'b0}) begin
            $display("FAIL ldr_write: regWE=%b DR=%0d bus=%0d mem_en=%b want 1 2 3 0",
                     regWE, DR, bus_sel, mem_en); miscompares++;
        end
        tick();
        Buss = 16'h0000;
        #1;
        vectors++;
        if (nzp !== 3'b100) begin
            $display("FAIL ldr_cc: got %b want 100", nzp); miscompares++;
        end
    endtask

    task automatic test_str();
        fetch(16'h7942, 0);
        tick();
        #1;
        vectors++;
        if ({ld_mar, addr1_sel, addr2_sel, SR1} !== {1'b1, 1'b1, 2'd1, 3'd5}) begin
            $display("FAIL str_addr: ld_mar=%b a1=%b a2=%0d SR1=%0d want 1 1 1 5",
                     ld_mar, addr1_sel, addr2_sel, SR1); miscompares++;
        end
        tick();
        #1;
        vectors++;
        if ({SR1, alu_op, mdr_sel, ld_mdr, bus_sel, mem_en} !== {3'd4, 2'd3, 1'b1, 1'b1, 2'd1, 1'b0}) begin
            $display("FAIL str_st2: SR1=%0d op=%0d mdr_sel=%b ld_mdr=%b bus=%0d want 4 3 1 1 1",
                     SR1, alu_op, mdr_sel, ld_mdr, bus_sel); miscompares++;
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            #1;
            vectors++;
            if ({mem_en, mem_we, regWE} !== 3'b110) begin
                $display("FAIL str_st3: cycle %0d en=%b we=%b regWE=%b want 1 1 0",
                         i, mem_en, mem_we, regWE); miscompares++;
            end
            tick();
        end
        mem_ready = 1'b0;
        #1;
        vectors++;
        if ({ld_mar, mem_en, mem_we, nzp} !== {1'b1, 1'b0, 1'b0, 3'b100}) begin
            $display("FAIL str_done: ld_mar=%b en=%b we=%b nzp=%b want 1 0 0 100",
                     ld_mar, mem_en, mem_we, nzp); miscompares++;
        end
    endtask

    task automatic test_jsr_jmp_lea();
        fetch(16'h41C0, 0);
        tick();
        #1;
        vectors++;
        if ({regWE, DR, bus_sel, ld_pc, addr1_sel, SR1, pc_sel, addr2_sel} !==
            {1'b1, 3'd7, 2'd0, 1'b1, 1'b1, 3'd7, 2'd1, 2'd0}) begin
            $display("FAIL jsrr: regWE=%b DR=%0d bus=%0d ld_pc=%b a1=%b SR1=%0d pc_sel=%0d a2=%0d",
                     regWE, DR, bus_sel, ld_pc, addr1_sel, SR1, pc_sel, addr2_sel); miscompares++;
        end
        tick();
        #1;
        vectors++;
        if (ld_mar !== 1'b1 || regWE !== 1'b0) begin
            $display("FAIL jsrr_one_cycle: ld_mar=%b regWE=%b want 1 0", ld_mar, regWE); miscompares++;
        end
        fetch(16'h4805, 0);
        tick();
        #1;
        vectors++;
        if ({addr1_sel, addr2_sel, DR, regWE} !== {1'b0, 2'd3, 3'd7, 1'b1}) begin
            $display("FAIL jsr_off11: a1=%b a2=%0d DR=%0d regWE=%b want 0 3 7 1",
                     addr1_sel, addr2_sel, DR, regWE); miscompares++;
        end
        tick();
        fetch(16'hC080, 0);
        tick();
        #1;
        vectors++;
        if ({SR1, addr1_sel, addr2_sel, pc_sel, ld_pc, regWE} !== {3'd2, 1'b1, 2'd0, 2'd1, 1'b1, 1'b0}) begin
            $display("FAIL jmp: SR1=%0d a1=%b a2=%0d pc_sel=%0d ld_pc=%b regWE=%b",
                     SR1, addr1_sel, addr2_sel, pc_sel, ld_pc, regWE); miscompares++;
        end
        tick();
        fetch(16'hE5FF, 0);
        tick();
        Buss = 16'h0000;
        #1;
        vectors++;
        if ({regWE, DR, bus_sel, addr1_sel, addr2_sel} !== {1'b1, 3'd2, 2'd2, 1'b0, 2'd2}) begin
            $display("FAIL lea: regWE=%b DR=%0d bus=%0d a1=%b a2=%0d want 1 2 2 0 2",
                     regWE, DR, bus_sel, addr1_sel, addr2_sel); miscompares++;
        end
        tick();
        #1;
        vectors++;
        if (nzp !== 3'b100) begin
            $display("FAIL lea_no_cc: got %b want 100", nzp); miscompares++;
        end
    endtask

    task automatic test_illegal();
        fetch(16'hF025, 0);
        vectors++;
        if (illegal !== 1'b1 || regWE !== 1'b0) begin
            $display("FAIL trap_dec: illegal=%b regWE=%b want 1 0", illegal, regWE); miscompares++;
        end
        tick();
        #1;
        vectors++;
        if ({illegal, ld_mar, regWE} !== 3'b010) begin
            $display("FAIL trap_next: illegal=%b ld_mar=%b regWE=%b want 0 1 0",
                     illegal, ld_mar, regWE); miscompares++;
        end
    endtask

    task automatic test_reset_in_wait();
        fetch(16'h2400, 1);
        tick();
        tick();
        mem_ready = 1'b0;
        #1;
        vectors++;
        if (mem_en !== 1'b1) begin
            $display("FAIL ld2_wait: mem_en=%b want 1", mem_en); miscompares++;
        end
        tick();
        reset = 1'b1; Buss = 16'h0000; mem_ready = 1'b1;
        #1;
        vectors++;
        if ({mem_en, regWE, ld_mdr} !== 3'b000) begin
            $display("FAIL reset_in_wait: en=%b regWE=%b ld_mdr=%b want 0 0 0",
                     mem_en, regWE, ld_mdr); miscompares++;
        end
        tick();
        reset = 1'b0; mem_ready = 1'b0;
        #1;
        vectors++;
        if ({ld_mar, ld_pc, regWE, nzp} !== {1'b1, 1'b1, 1'b0, 3'b010}) begin
            $display("FAIL reset_resume: ld_mar=%b ld_pc=%b regWE=%b nzp=%b want 1 1 0 010",
                     ld_mar, ld_pc, regWE, nzp); miscompares++;
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b1; Buss = 16'h0000; mem_ready = 1'b0;
        test_reset();
        test_add_imm();
        test_branch();
        test_ldr_wait();
        test_str();
        test_jsr_jmp_lea();
        test_illegal();
        test_reset_in_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
